// File: rtl/led_chaser_param.sv
// led_chaser_param: parametrised LED chaser for the DE-board LED bank.
// A tick counter, whose period is picked from SW by a priority encoder
// (lowest asserted switch wins), advances one of four display patterns:
// bounce, rotate-left, rotate-right and bar-fill.
//
// Ports:
//   CLOCK_50  in   system clock
//   KEY0      in   asynchronous active-low reset
//   KEY1      in   active-low pause (held low freezes the display)
//   SW        in   [N_SPEEDS] speed select, lowest asserted index wins
//   MODE      in   [2] 00 bounce, 01 rotate-left, 10 rotate-right, 11 bar-fill
//   LEDG      out  [N_LEDS] LED pattern
//   DIR       out  bounce direction (0 toward MSB, 1 toward LSB), 0 in other modes
//   STEP_P    out  one-cycle pulse coincident with every display advance
module led_chaser_param #(
  parameter int N_LEDS   = 8,
  parameter int N_SPEEDS = 10,
  parameter int STEP     = 1000000,
  parameter int CNT_W    = 26
) (
  input  logic                CLOCK_50,
  input  logic                KEY0,
  input  logic                KEY1,
  input  logic [N_SPEEDS-1:0] SW,
  input  logic [1:0]          MODE,
  output logic [N_LEDS-1:0]   LEDG,
  output logic                DIR,
  output logic                STEP_P
);

  localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int LW = $clog2(N_LEDS + 1);

  localparam logic [PW-1:0] POS_LAST = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] POS_PREV = PW'(N_LEDS - 2);
  localparam logic [LW-1:0] LVL_FULL = LW'(N_LEDS);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_ROL    = 2'b01,
    MODE_ROR    = 2'b10,
    MODE_BAR    = 2'b11
  } mode_e;

  // Input synchronisers
  logic                key1_s1_q, key1_s2_q;
  logic [N_SPEEDS-1:0] sw_s1_q, sw_s2_q;
  mode_e               mode_s1_q, mode_s2_q;

  // Display and timing state
  mode_e               mode_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic                dir_q, dir_d;
  logic                step_q, step_d;

  logic [CNT_W-1:0]    limit;
  logic                paused;
  logic                mode_chg;
  logic                at_limit;

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      key1_s1_q <= 1'b1;
      key1_s2_q <= 1'b1;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      mode_s1_q <= MODE_BOUNCE;
      mode_s2_q <= MODE_BOUNCE;
    end else begin
      key1_s1_q <= KEY1;
      key1_s2_q <= key1_s1_q;
      sw_s1_q   <= SW;
      sw_s2_q   <= sw_s1_q;
      mode_s1_q <= mode_e'(MODE);
      mode_s2_q <= mode_s1_q;
    end
  end

  // Priority encoder: scan from the top so the lowest asserted switch is
  // the last assignment and therefore wins.
  always_comb begin
    limit = CNT_W'((N_SPEEDS + 1) * STEP);
    for (int unsigned i = N_SPEEDS; i > 0; i--) begin
      if (sw_s2_q[i-1]) limit = CNT_W'((N_SPEEDS + 1 - i) * STEP);
    end
  end

  assign paused   = ~key1_s2_q;
  assign mode_chg = (mode_s2_q != mode_q);
  // >= rather than == so a limit lowered below the current count fires at
  // once instead of waiting for the counter to wrap.
  assign at_limit = (cnt_q >= (limit - CNT_W'(1)));

  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    lvl_d  = lvl_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (mode_chg) begin
      // Reinit takes priority over a tick due in the same cycle.
      cnt_d = '0;
      pos_d = '0;
      lvl_d = '0;
      dir_d = 1'b0;
    end else if (!paused) begin
      if (at_limit) begin
        cnt_d  = '0;
        step_d = 1'b1;
        unique case (mode_q)
          MODE_BOUNCE: begin
            if (!dir_q) begin
              if (pos_q == POS_LAST) begin
                pos_d = POS_PREV;
                dir_d = 1'b1;
              end else begin
                pos_d = pos_q + PW'(1);
              end
            end else begin
              if (pos_q == '0) begin
                pos_d = PW'(1);
                dir_d = 1'b0;
              end else begin
                pos_d = pos_q - PW'(1);
              end
            end
          end
          MODE_ROL: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
          MODE_ROR: pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
          MODE_BAR: lvl_d = (lvl_q == LVL_FULL) ? '0 : lvl_q + LW'(1);
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      mode_q <= MODE_BOUNCE;
      cnt_q  <= '0;
      pos_q  <= '0;
      lvl_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_s2_q;
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      lvl_q  <= lvl_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  // Pattern decoded straight from state so an asynchronous reset shows on
  // the LEDs without waiting for a clock edge.
  always_comb begin
    LEDG = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (mode_q == MODE_BAR) LEDG[i] = (LW'(i) < lvl_q);
      else                    LEDG[i] = (PW'(i) == pos_q);
    end
  end

  assign DIR    = dir_q;
  assign STEP_P = step_q;

endmodule

// File: tb/tb_led_chaser_param.sv
// Directed testbench for led_chaser_param with N_LEDS=4, N_SPEEDS=4, STEP=2.
module tb_led_chaser_param;

  logic       clk;
  logic       KEY0;
  logic       KEY1;
  logic [3:0] SW;
  logic [1:0] MODE;
  logic [3:0] LEDG;
  logic       DIR;
  logic       STEP_P;

  int checks   = 0;
  int failures = 0;

  led_chaser_param #(
    .N_LEDS  (4),
    .N_SPEEDS(4),
    .STEP    (2),
    .CNT_W   (8)
  ) dut (
    .CLOCK_50(clk),
    .KEY0    (KEY0),
    .KEY1    (KEY1),
    .SW      (SW),
    .MODE    (MODE),
    .LEDG    (LEDG),
    .DIR     (DIR),
    .STEP_P  (STEP_P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the next STEP_P, then check the cycles taken, the
  // new pattern and direction, and that LEDG held still until the pulse.
  task automatic expect_step(input string tag, input int exp_per,
                             input logic [3:0] exp_led, input logic exp_dir);
    int         n;
    logic [3:0] led0;
    logic       held;
    led0 = LEDG;
    held = 1'b1;
    n    = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!STEP_P && LEDG !== led0) held = 1'b0;
    end while (!STEP_P && n < 64);
    check({tag, "_period"}, n, exp_per);
    check({tag, "_led"}, LEDG, exp_led);
    check({tag, "_dir"}, DIR, exp_dir);
    check({tag, "_hold"}, held, 1'b1);
  endtask

  // Apply a MODE change, check the two sync cycles, then the reinit cycle.
  task automatic change_mode(input string tag, input logic [1:0] m,
                             input logic [3:0] led_pre, input logic step_pre,
                             input logic [3:0] led_post);
    MODE = m;
    repeat (2) begin @(posedge clk); #1; end
    check({tag, "_pre_led"}, LEDG, led_pre);
    check({tag, "_pre_stp"}, STEP_P, step_pre);
    @(posedge clk); #1;
    check({tag, "_led"}, LEDG, led_post);
    check({tag, "_stp"}, STEP_P, 1'b0);
    check({tag, "_dir"}, DIR, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t1_led [7] = '{4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd2};
    logic       t1_dir [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       held;

    KEY0 = 1'b0;
    KEY1 = 1'b1;
    SW   = 4'b0000;
    MODE = 2'b00;
    @(posedge clk); #1;
    check("rst_led", LEDG, 4'd1);
    check("rst_dir", DIR, 1'b0);
    check("rst_stp", STEP_P, 1'b0);
    @(posedge clk);
    @(negedge clk);
    KEY0 = 1'b1;

    // 1: bounce at the default period of 10
    for (int i = 0; i < 7; i++) expect_step($sformatf("bounce%0d", i), 10, t1_led[i], t1_dir[i]);

    // 2: speed select
    SW = 4'b0001;
    expect_step("sw0_a", 8, 4'd4, 1'b0);
    expect_step("sw0_b", 8, 4'd8, 1'b0);
    SW = 4'b1000;
    expect_step("sw3_a", 3, 4'd4, 1'b1);
    expect_step("sw3_b", 2, 4'd2, 1'b1);
    expect_step("sw3_c", 2, 4'd1, 1'b1);
    SW = 4'b1001;
    expect_step("sw30_a", 2, 4'd2, 1'b0);
    expect_step("sw30_b", 8, 4'd4, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    SW = 4'b1000;
    expect_step("sw_reduce", 3, 4'd8, 1'b0);

    // 3: rotate-left, rotate-right, bar-fill at period 2
    change_mode("to_rol", 2'b01, 4'd4, 1'b1, 4'd1);
    expect_step("rol0", 2, 4'd2, 1'b0);
    expect_step("rol1", 2, 4'd4, 1'b0);
    expect_step("rol2", 2, 4'd8, 1'b0);
    expect_step("rol3", 2, 4'd1, 1'b0);
    change_mode("to_ror", 2'b10, 4'd2, 1'b1, 4'd1);
    expect_step("ror0", 2, 4'd8, 1'b0);
    expect_step("ror1", 2, 4'd4, 1'b0);
    expect_step("ror2", 2, 4'd2, 1'b0);
    expect_step("ror3", 2, 4'd1, 1'b0);
    change_mode("to_bar", 2'b11, 4'd8, 1'b1, 4'd0);
    expect_step("bar0", 2, 4'd1, 1'b0);
    expect_step("bar1", 2, 4'd3, 1'b0);
    expect_step("bar2", 2, 4'd7, 1'b0);
    expect_step("bar3", 2, 4'd15, 1'b0);
    expect_step("bar4", 2, 4'd0, 1'b0);
    SW = 4'b0000;
    expect_step("bar5", 2, 4'd1, 1'b0);
    expect_step("bar6", 10, 4'd3, 1'b0);

    // 4: pause mid-period for 25 cycles
    repeat (4) begin @(posedge clk); #1; end
    KEY1 = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (LEDG !== 4'd3 || STEP_P !== 1'b0) held = 1'b0;
    end
    check("pause_hold", held, 1'b1);
    KEY1 = 1'b1;
    expect_step("pause_resume", 6, 4'd7, 1'b0);

    // 5: mode change landing on the cycle a tick is due
    change_mode("to_bnc", 2'b00, 4'd7, 1'b0, 4'd1);
    expect_step("bnc_a", 10, 4'd2, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    change_mode("tick_vs_mode", 2'b11, 4'd2, 1'b0, 4'd0);
    expect_step("after_reinit", 10, 4'd1, 1'b0);

    // 6: asynchronous reset between edges while LEDG = 8
    change_mode("to_bnc2", 2'b00, 4'd1, 1'b0, 4'd1);
    expect_step("bnc2_a", 10, 4'd2, 1'b0);
    expect_step("bnc2_b", 10, 4'd4, 1'b0);
    expect_step("bnc2_c", 10, 4'd8, 1'b0);
    #3;
    KEY0 = 1'b0;
    #1;
    check("arst_led", LEDG, 4'd1);
    check("arst_dir", DIR, 1'b0);
    check("arst_stp", STEP_P, 1'b0);
    #2;
    KEY0 = 1'b1;
    expect_step("post_rst_a", 10, 4'd2, 1'b0);
    expect_step("post_rst_b", 10, 4'd4, 1'b0);
    expect_step("post_rst_c", 10, 4'd8, 1'b0);
    expect_step("post_rst_d", 10, 4'd4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
